pulse_cmd_sequencer: RTL and testbench



---
 rtl/pulse_cmd_pkg.sv | 25 ++
 rtl/cmd_frame_assembler.sv | 79 +++++++
 rtl/pulse_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_pulse_cmd_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cmd_pkg.sv
// Shared constants, FSM state encoding and field clamp helper for the pulse command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_cmd_pkg;

    localparam logic [7:0] HDR       = 8'h07;
    localparam logic [7:0] ACK       = 8'hA5;
    localparam logic [7:0] NAK       = 8'hEE;
    localparam int         FRAME_LEN = 10;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        APPLY,
        FIRE,
        REPLY
    } state_t;

    // Raise a 16-bit timing field to the generator's minimum usable value.
    function automatic logic [15:0] clamp_min(input logic [15:0] v, input logic [15:0] floor_v);
        return (v < floor_v) ? floor_v : v;
    endfunction

endpackage

// File: rtl/cmd_frame_assembler.sv
// Collects a 10-byte config frame, keeps a running XOR and an inter-byte timeout.
// Latency: frame_done is combinational on the b9 strobe; chk_ok/fields valid the cycle after.
// Backpressure: none; bytes are only taken while the FSM reports IDLE or RECV.
module cmd_frame_assembler
    import pulse_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 156_250
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_in_idle,
    input  logic        i_in_recv,
    output logic        o_frame_done,
    output logic        o_chk_ok,
    output logic        o_abort,
    output logic [15:0] o_width1,
    output logic [15:0] o_width2,
    output logic [15:0] o_gap,
    output logic [1:0]  o_ch_en
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    r_cnt;
    logic [7:0]    r_buf [0:FRAME_LEN-1];
    logic [7:0]    r_xor;
    logic [TW-1:0] r_timer;

    logic w_start;
    logic w_store;

    assign w_start = i_in_idle && i_rx_valid && (i_rx_data == HDR);
    assign w_store = i_in_recv && i_rx_valid;

    assign o_frame_done = w_store && (r_cnt == 4'(FRAME_LEN - 1));
    // XOR over all ten bytes is zero exactly when b9 equals XOR of b0..b8.
    assign o_chk_ok     = (r_xor == 8'h00);
    assign o_abort      = i_in_recv && !i_rx_valid && (r_timer == TW'(TIMEOUT_CYC - 1));

    assign o_width1 = {r_buf[3], r_buf[4]};
    assign o_width2 = {r_buf[5], r_buf[6]};
    assign o_gap    = {r_buf[7], r_buf[8]};
    assign o_ch_en  = {r_buf[2][0], r_buf[1][0]};

    // Byte counter, running checksum and idle timer; timer restarts on every accepted byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 4'd0;
            r_xor   <= 8'h00;
            r_timer <= '0;
        end else if (w_start) begin
            r_cnt   <= 4'd1;
            r_xor   <= i_rx_data;
            r_timer <= '0;
        end else if (w_store) begin
            r_cnt   <= r_cnt + 4'd1;
            r_xor   <= r_xor ^ i_rx_data;
            r_timer <= '0;
        end else if (i_in_recv) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Shadow buffer: header lands in slot 0, later bytes at the current count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_start) begin
            r_buf[0] <= i_rx_data;
        end else if (w_store) begin
            r_buf[r_cnt] <= i_rx_data;
        end
    end

endmodule

// File: rtl/pulse_cmd_sequencer.sv
// UART config-frame parser, atomic config commit and key/frame fire arbitration with ACK/NAK reply.
// Latency: b9 at cycle N -> commit at end of N+2, fire during N+3, tx_flag during N+4.
// Backpressure: commit stalls on gen_busy, reply stalls on tx_busy; rx bytes outside IDLE/RECV dropped.
module pulse_cmd_sequencer
    import pulse_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 156_250,
    parameter int MIN_VAL     = 4,
    parameter int DEF_VAL     = 5
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_key_trig,
    input  logic        i_gen_busy,
    input  logic        i_tx_busy,
    output logic [15:0] o_pulse_width1,
    output logic [15:0] o_pulse_width2,
    output logic [15:0] o_pulse_gap,
    output logic [1:0]  o_ch_en,
    output logic        o_fire,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_flag
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_width1;
    logic [15:0] r_width2;
    logic [15:0] r_gap;
    logic [1:0]  r_ch_en;
    logic        r_fire;
    logic        r_key_pend;
    logic [7:0]  r_tx_data;

    logic        w_frame_done;
    logic        w_chk_ok;
    logic        w_abort;
    logic [15:0] w_sh_width1;
    logic [15:0] w_sh_width2;
    logic [15:0] w_sh_gap;
    logic [1:0]  w_sh_ch_en;
    logic        w_commit;
    logic        w_key_ok;
    logic        w_key_fire;

    cmd_frame_assembler #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .i_clk        (i_sys_clk),
        .i_rst        (i_sys_rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .i_in_idle    (r_state == IDLE),
        .i_in_recv    (r_state == RECV),
        .o_frame_done (w_frame_done),
        .o_chk_ok     (w_chk_ok),
        .o_abort      (w_abort),
        .o_width1     (w_sh_width1),
        .o_width2     (w_sh_width2),
        .o_gap        (w_sh_gap),
        .o_ch_en      (w_sh_ch_en)
    );

    // A strobe already in flight also holds off the commit, so a key fire issued
    // from CHECK can never be followed by the frame fire on the very next cycle.
    assign w_commit   = (r_state == APPLY) && !i_gen_busy && !r_fire;
    assign w_key_ok   = !i_gen_busy && (r_state != APPLY) && (r_state != FIRE) && !r_fire;
    assign w_key_fire = w_key_ok && (i_key_trig || r_key_pend);

    // State register.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_rx_valid && (i_rx_data == HDR)) w_state_nxt = RECV;
            RECV: begin
                if (w_frame_done)  w_state_nxt = CHECK;
                else if (w_abort)  w_state_nxt = IDLE;
            end
            CHECK:   w_state_nxt = w_chk_ok ? APPLY : REPLY;
            APPLY:   if (w_commit) w_state_nxt = FIRE;
            FIRE:    w_state_nxt = REPLY;
            REPLY:   if (!i_tx_busy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Committed config: all fields change together on the commit edge.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_width1 <= 16'(DEF_VAL);
            r_width2 <= 16'(DEF_VAL);
            r_gap    <= 16'(DEF_VAL);
            r_ch_en  <= 2'b11;
        end else if (w_commit) begin
            r_width1 <= clamp_min(w_sh_width1, 16'(MIN_VAL));
            r_width2 <= clamp_min(w_sh_width2, 16'(MIN_VAL));
            r_gap    <= clamp_min(w_sh_gap, 16'(MIN_VAL));
            r_ch_en  <= w_sh_ch_en;
        end
    end

    // Fire arbitration: frame commit and key requests share one strobe; a key
    // arriving on the commit cycle is absorbed into the frame fire.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_fire     <= 1'b0;
            r_key_pend <= 1'b0;
        end else begin
            r_fire <= w_commit || w_key_fire;
            if (w_key_fire) begin
                r_key_pend <= 1'b0;
            end else if (i_key_trig && !w_commit) begin
                r_key_pend <= 1'b1;
            end
        end
    end

    // Reply byte: NAK chosen on a bad checksum, ACK once the frame has fired.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_tx_data <= 8'h00;
        end else if ((r_state == CHECK) && !w_chk_ok) begin
            r_tx_data <= NAK;
        end else if (r_state == FIRE) begin
            r_tx_data <= ACK;
        end
    end

    assign o_pulse_width1 = r_width1;
    assign o_pulse_width2 = r_width2;
    assign o_pulse_gap    = r_gap;
    assign o_ch_en        = r_ch_en;
    assign o_fire         = r_fire;
    assign o_tx_data      = r_tx_data;
    assign o_tx_flag      = (r_state == REPLY) && !i_tx_busy;

endmodule

// File: tb/tb_pulse_cmd_sequencer.sv
// Directed plus randomized frames checked against a frame-level reference model.
// Latency: exact cycle checks on the nominal path, bounded waits elsewhere.
// Backpressure: gen_busy and tx_busy are held for random spans.
module tb_pulse_cmd_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        key_trig = 1'b0;
    logic        gen_busy = 1'b0;
    logic        tx_busy = 1'b0;
    logic [15:0] pulse_width1;
    logic [15:0] pulse_width2;
    logic [15:0] pulse_gap;
    logic [1:0]  ch_en;
    logic        fire;
    logic [7:0]  tx_data;
    logic        tx_flag;

    always #5 clk = ~clk;

    pulse_cmd_sequencer #(
        .TIMEOUT_CYC (TO),
        .MIN_VAL     (4),
        .DEF_VAL     (5)
    ) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_key_trig     (key_trig),
        .i_gen_busy     (gen_busy),
        .i_tx_busy      (tx_busy),
        .o_pulse_width1 (pulse_width1),
        .o_pulse_width2 (pulse_width2),
        .o_pulse_gap    (pulse_gap),
        .o_ch_en        (ch_en),
        .o_fire         (fire),
        .o_tx_data      (tx_data),
        .o_tx_flag      (tx_flag)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          fire_cnt = 0;
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'h00;
    logic        prev_fire = 1'b0;
    logic [7:0]  fr [10];
    logic [15:0] exp_w1 = 16'd5;
    logic [15:0] exp_w2 = 16'd5;
    logic [15:0] exp_gap = 16'd5;
    logic [1:0]  exp_en = 2'b11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Mid-cycle monitor: counts strobes and records the byte sent with each tx_flag.
    always @(negedge clk) begin
        if (fire === 1'b1) begin
            fire_cnt++;
            check("fire_back_to_back", {31'd0, prev_fire}, 32'd0);
            check("fire_while_busy", {31'd0, gen_busy}, 32'd0);
        end
        if (tx_flag === 1'b1) begin
            tx_cnt++;
            tx_last = tx_data;
        end
        prev_fire = fire;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input logic ch1, input logic ch2, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] g, input logic corrupt);
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] x;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        fr[0] = 8'h07;
        fr[1] = {r1[7:1], ch1};
        fr[2] = {r2[7:1], ch2};
        fr[3] = w1[15:8];
        fr[4] = w1[7:0];
        fr[5] = w2[15:8];
        fr[6] = w2[7:0];
        fr[7] = g[15:8];
        fr[8] = g[7:0];
        x = 8'h00;
        for (int i = 0; i < 9; i++) x = x ^ fr[i];
        fr[9] = corrupt ? (x ^ 8'($urandom_range(1, 255))) : x;
    endtask

    function automatic logic [15:0] clampv(input logic [15:0] v);
        return (v < 16'd4) ? 16'd4 : v;
    endfunction

    // Reference: a frame whose ten bytes XOR to zero updates the expected config.
    task automatic model_apply(output logic ok);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 10; i++) x = x ^ fr[i];
        ok = (x == 8'h00);
        if (ok) begin
            exp_w1  = clampv({fr[3], fr[4]});
            exp_w2  = clampv({fr[5], fr[6]});
            exp_gap = clampv({fr[7], fr[8]});
            exp_en  = {fr[2][0], fr[1][0]};
        end
    endtask

    task automatic send_frame(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = fr[i];
            step();
            rx_valid = 1'b0;
            if (i < n - 1) repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    task automatic wait_tx(input int start);
        int k;
        k = 0;
        while (tx_cnt == start && k < 80) begin
            step();
            k++;
        end
        check("tx_flag_wait", {31'd0, tx_cnt != start}, 32'd1);
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_w1"}, {16'd0, pulse_width1}, {16'd0, exp_w1});
        check({tag, "_w2"}, {16'd0, pulse_width2}, {16'd0, exp_w2});
        check({tag, "_gap"}, {16'd0, pulse_gap}, {16'd0, exp_gap});
        check({tag, "_en"}, {30'd0, ch_en}, {30'd0, exp_en});
    endtask

    initial begin
        int          f0;
        int          t0;
        logic        ok;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] g;
        logic        bad;
        int          hold;
        int          txh;

        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state.
        check_cfg("reset");
        check("reset_fire", {31'd0, fire}, 32'd0);
        check("reset_tx_flag", {31'd0, tx_flag}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);

        // Bad checksum: NAK, no fire, config untouched.
        make_frame(1'b1, 1'b1, 16'd10, 16'd20, 16'd30, 1'b0);
        fr[9] = 8'h00;
        model_apply(ok);
        f0 = fire_cnt;
        t0 = tx_cnt;
        send_frame(10, 0);
        wait_tx(t0);
        step();
        check("nak_byte", {24'd0, tx_last}, 32'hEE);
        check_cfg("nak_cfg");
        check("nak_nofire", fire_cnt - f0, 32'd0);

        // Nominal frame with exact latency.
        make_frame(1'b1, 1'b1, 16'd10, 16'd20, 16'd30, 1'b0);
        model_apply(ok);
        f0 = fire_cnt;
        send_frame(10, 0);
        check("lat_n1_fire", {31'd0, fire}, 32'd0);
        step();
        check("lat_n2_fire", {31'd0, fire}, 32'd0);
        step();
        check("lat_n3_fire", {31'd0, fire}, 32'd1);
        step();
        check("lat_n4_tx_flag", {31'd0, tx_flag}, 32'd1);
        check("lat_n4_tx_data", {24'd0, tx_data}, 32'hA5);
        check("ack_w1_abs", {16'd0, pulse_width1}, 32'd10);
        check_cfg("ack_cfg");
        step();
        check("ack_one_fire", fire_cnt - f0, 32'd1);

        // Clamp of small fields.
        make_frame(1'b0, 1'b1, 16'd2, 16'd3, 16'd100, 1'b0);
        model_apply(ok);
        t0 = tx_cnt;
        send_frame(10, 1);
        wait_tx(t0);
        check("clamp_w1_abs", {16'd0, pulse_width1}, 32'd4);
        check("clamp_ack", {24'd0, tx_last}, 32'hA5);
        check_cfg("clamp_cfg");

        // Partial frame times out silently, the next full frame is accepted.
        make_frame(1'b1, 1'b0, 16'h1234, 16'h0055, 16'h0066, 1'b0);
        t0 = tx_cnt;
        send_frame(5, 0);
        repeat (TO + 1) step();
        check("timeout_no_reply", tx_cnt - t0, 32'd0);
        make_frame(1'b1, 1'b1, 16'd40, 16'd50, 16'd60, 1'b0);
        model_apply(ok);
        send_frame(10, 0);
        wait_tx(t0);
        check("timeout_next_ack", {24'd0, tx_last}, 32'hA5);
        check_cfg("timeout_cfg");

        // Key trigger while idle fires on the next cycle.
        step();
        f0 = fire_cnt;
        key_trig = 1'b1;
        step();
        key_trig = 1'b0;
        check("key_idle_fire", {31'd0, fire}, 32'd1);
        step();
        check("key_idle_single", fire_cnt - f0, 32'd1);

        // Two keys while busy collapse into one fire after busy drops.
        gen_busy = 1'b1;
        f0 = fire_cnt;
        key_trig = 1'b1;
        step();
        key_trig = 1'b0;
        step();
        key_trig = 1'b1;
        step();
        key_trig = 1'b0;
        step();
        check("key_busy_hold", fire_cnt - f0, 32'd0);
        gen_busy = 1'b0;
        step();
        check("key_busy_fire", {31'd0, fire}, 32'd1);
        repeat (4) step();
        check("key_busy_single", fire_cnt - f0, 32'd1);

        // Frame completing while busy commits only once busy clears.
        gen_busy = 1'b1;
        make_frame(1'b1, 1'b0, 16'd111, 16'd222, 16'd333, 1'b0);
        f0 = fire_cnt;
        t0 = tx_cnt;
        send_frame(10, 0);
        repeat (4) step();
        check_cfg("busy_hold");
        check("busy_nofire", fire_cnt - f0, 32'd0);
        check("busy_noreply", tx_cnt - t0, 32'd0);
        model_apply(ok);
        gen_busy = 1'b0;
        step();
        check("busy_fire", {31'd0, fire}, 32'd1);
        check_cfg("busy_commit");
        step();
        check("busy_tx_flag", {31'd0, tx_flag}, 32'd1);
        check("busy_tx_data", {24'd0, tx_data}, 32'hA5);

        // Reset mid-frame drops partial data and restores reset values.
        step();
        make_frame(1'b1, 1'b0, 16'd7, 16'd8, 16'd9, 1'b0);
        t0 = tx_cnt;
        send_frame(4, 0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        exp_w1 = 16'd5;
        exp_w2 = 16'd5;
        exp_gap = 16'd5;
        exp_en = 2'b11;
        check_cfg("rst_mid");
        check("rst_mid_fire", {31'd0, fire}, 32'd0);
        check("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_mid_tx_flag", {31'd0, tx_flag}, 32'd0);
        repeat (TO + 4) step();
        check("rst_mid_no_reply", tx_cnt - t0, 32'd0);
        check_cfg("rst_mid_after");

        // Randomized frames with noise bytes, byte gaps, corrupt checksums and backpressure.
        for (int it = 0; it < 24; it++) begin
            w1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            w2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            g  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom_range(8, 255));
                step();
                rx_valid = 1'b0;
            end
            hold = $urandom_range(0, 4);
            txh  = $urandom_range(0, 3);
            gen_busy = (hold != 0);
            tx_busy  = (txh != 0);
            make_frame(1'($urandom), 1'($urandom), w1, w2, g, bad);
            model_apply(ok);
            f0 = fire_cnt;
            t0 = tx_cnt;
            send_frame(10, 2);
            repeat (hold) step();
            gen_busy = 1'b0;
            repeat (txh) step();
            tx_busy = 1'b0;
            wait_tx(t0);
            step();
            step();
            check("rand_reply", {24'd0, tx_last}, ok ? 32'hA5 : 32'hEE);
            check_cfg("rand_cfg");
            check("rand_fires", fire_cnt - f0, ok ? 32'd1 : 32'd0);
            check("rand_one_reply", tx_cnt - t0, 32'd1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
